dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Arbitrates the single-port data memory between the CPU MEM stage (driven from the EX/MEM
//  pipeline register outputs) and a burst DMA requester. CPU has priority; DMA is
//  starvation-protected by a wait counter. Raises cpu_stall to freeze the EX/MEM register
//  and earlier stages while DMA owns memory. Sits between the EX/MEM register and data memory.
// PARAMETERS
//  ADDR_W     16  data memory word-address width
//  DATA_W     32  data word width
//  BURST_LEN   8  max DMA beats per grant (>=1)
//  MAX_WAIT    4  contended cycles before DMA overrides CPU priority (>=1)
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst        in   1       asynchronous, active-high reset
//  cpu_rd     in   1       MEM-stage load (EX/MEM MemRead)
//  cpu_wr     in   1       MEM-stage store (EX/MEM MemWrite)
//  cpu_addr   in   ADDR_W  MEM-stage address (EX/MEM ALU result)
//  cpu_wdata  in   DATA_W  MEM-stage store data
//  cpu_rdata  out  DATA_W  load data, = mem_rdata
//  cpu_stall  out  1       hold pipeline; CPU access not serviced this cycle
//  dma_req    in   1       DMA wants memory / presents a beat while granted
//  dma_we     in   1       beat is a write
//  dma_addr   in   ADDR_W  beat address
//  dma_wdata  in   DATA_W  beat write data
//  dma_gnt    out  1       DMA owns memory this cycle
//  dma_rdata  out  DATA_W  DMA read data, = mem_rdata
//  dma_rvalid out  1       dma_rdata valid (1 cycle after a DMA read beat)
//  dma_done   out  1       1-cycle pulse, cycle after grant ends
//  mem_addr   out  ADDR_W  memory address
//  mem_we     out  1       memory write enable
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, 1-cycle synchronous read latency
// BEHAVIOUR
//  - States: CPU (reset state), DMA. dma_gnt = (state==DMA), decoded from the state register.
//  - cpu_acc = cpu_rd|cpu_wr. beat = dma_gnt & dma_req.
//  - Memory mux (comb): state CPU -> mem_* from cpu_*, mem_we=cpu_wr; state DMA -> mem_* from
//    dma_*, mem_we=beat&dma_we. Idle cycles drive mem_we=0.
//  - cpu_stall = (state==DMA) & cpu_acc; 0 in state CPU (CPU always serviced there).
//  - wait_cnt: in CPU, +1 when dma_req&cpu_acc, saturates at MAX_WAIT; cleared on entry to DMA.
//  - CPU->DMA when dma_req & (!cpu_acc | wait_cnt==MAX_WAIT); the CPU access in the deciding
//    cycle is still serviced; dma_gnt rises next cycle. beat_cnt cleared to 0 on entry.
//  - In DMA: beat_cnt +1 per beat. DMA->CPU when beat & beat_cnt==BURST_LEN-1 (final beat is
//    serviced), or when dma_req=0 (early end, no beat). dma_done=1 the following cycle.
//  - dma_rvalid registered: 1 the cycle after a beat with dma_we=0, else 0.
//  - After DMA->CPU, wait_cnt=0; DMA re-grant follows the normal CPU-state rule.
//  - Reset (any time, incl. mid-burst): state CPU, wait_cnt=0, beat_cnt=0, dma_gnt=0,
//    dma_rvalid=0, dma_done=0, cpu_stall=0; interrupted burst gets no dma_done, DMA re-requests.
//  - Counters sized clog2(MAX_WAIT+1) and clog2(BURST_LEN); no wrap possible.
// TESTING
//  1. CPU only: cpu_rd @0x0010 holding 0xDEADBEEF -> cpu_rdata=0xDEADBEEF next cycle, cpu_stall=0
//     throughout, dma_gnt=0.
//  2. CPU idle, dma_req+dma_we 4 beats @0x0100..0x0103 then dma_req=0 -> dma_gnt next cycle,
//     4 writes land, dma_gnt falls, dma_done pulses once, CPU state resumes.
//  3. cpu_rd and dma_req held from cycle 0 -> CPU serviced cycles 0-4, dma_gnt=1 cycles 5-12
//     (8 beats), cpu_stall=1 cycles 5-12, dma_done cycle 13, CPU serviced cycle 13.
//  4. DMA read burst of 3 from 0x0200 (0xA,0xB,0xC) -> dma_rvalid high 3 cycles, each one
//     after its beat, dma_rdata = 0xA,0xB,0xC in order.
//  5. rst asserted async at DMA beat 3 -> dma_gnt, cpu_stall, dma_rvalid drop immediately;
//     after release CPU store serviced, no dma_done pulse.
//  6. cpu_wr 1 cycle with dma_req, wait_cnt=0 -> store serviced, then CPU idle -> dma_gnt next
//     cycle; cpu_wr during DMA -> cpu_stall=1, store held, serviced after dma_gnt falls.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the CPU MEM stage (fed from the
//   EX/MEM pipeline register) and a burst DMA requester. The CPU has priority;
//   the DMA side is protected from starvation by a wait counter that forces a
//   grant after MAX_WAIT contended cycles. While the DMA owns memory, any CPU
//   access is stalled through cpu_stall.
//
// Ports
//   clk, rst      rising-edge clock; asynchronous active-high reset
//   cpu_rd/wr     MEM-stage load / store request
//   cpu_addr      MEM-stage word address
//   cpu_wdata     MEM-stage store data
//   cpu_rdata     load data (mem_rdata passthrough, valid one cycle after the load)
//   cpu_stall     CPU access present but not serviced this cycle
//   dma_req       DMA request / beat valid
//   dma_we        DMA beat is a write
//   dma_addr      DMA beat address
//   dma_wdata     DMA beat write data
//   dma_gnt       DMA owns memory this cycle (decoded FSM state, doubles as debug view)
//   dma_rdata     DMA read data (mem_rdata passthrough)
//   dma_rvalid    dma_rdata valid, one cycle after a DMA read beat
//   dma_done      one-cycle pulse in the cycle after a grant ends
//   mem_addr      memory word address
//   mem_we        memory write enable
//   mem_wdata     memory write data
//   mem_rdata     memory read data, one-cycle synchronous read latency
//
// DMA handshake: dma_req is the valid and dma_gnt is the ready. A beat transfers
// in every cycle where both are high; dma_req low while granted ends the burst
// without a transfer. The DMA must hold its beat (address/data/we) until it sees
// dma_gnt.

module dmem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 8,
    parameter int MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              dma_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    typedef enum logic {
        ST_CPU = 1'b0,
        ST_DMA = 1'b1
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitCntNext;
    logic [BEAT_W-1:0] beatCnt;
    logic [BEAT_W-1:0] beatCntNext;
    logic              doneNext;
    logic              rvalidNext;

    logic cpuAcc;
    logic beat;
    logic waitExpired;
    logic lastBeat;

    assign cpuAcc      = cpu_rd | cpu_wr;
    assign beat        = (state == ST_DMA) & dma_req;
    assign waitExpired = (waitCnt == WAIT_MAX);
    assign lastBeat    = (beatCnt == BEAT_LAST);

    // Next-state logic. The CPU access in the cycle that decides a grant is
    // still serviced; ownership changes only at the following edge.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        beatCntNext = beatCnt;
        doneNext    = 1'b0;
        case (state)
            ST_CPU: begin
                if (dma_req & (~cpuAcc | waitExpired)) begin
                    stateNext   = ST_DMA;
                    waitCntNext = '0;
                    beatCntNext = '0;
                end else if (dma_req & cpuAcc) begin
                    // Only reached while waitCnt < MAX_WAIT, so this cannot wrap.
                    waitCntNext = waitCnt + WAIT_W'(1);
                end
            end
            ST_DMA: begin
                if (!dma_req) begin
                    // Early end: no beat this cycle.
                    stateNext   = ST_CPU;
                    doneNext    = 1'b1;
                    waitCntNext = '0;
                end else if (lastBeat) begin
                    // Final beat is serviced in this cycle.
                    stateNext   = ST_CPU;
                    doneNext    = 1'b1;
                    waitCntNext = '0;
                end else begin
                    beatCntNext = beatCnt + BEAT_W'(1);
                end
            end
            default: stateNext = ST_CPU;
        endcase
    end

    assign rvalidNext = beat & ~dma_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_CPU;
            waitCnt    <= '0;
            beatCnt    <= '0;
            dma_done   <= 1'b0;
            dma_rvalid <= 1'b0;
        end else begin
            state      <= stateNext;
            waitCnt    <= waitCntNext;
            beatCnt    <= beatCntNext;
            dma_done   <= doneNext;
            dma_rvalid <= rvalidNext;
        end
    end

    assign dma_gnt   = (state == ST_DMA);
    assign cpu_stall = dma_gnt & cpuAcc;
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

    // Memory port mux: owner drives address and data; in DMA state the write
    // enable is qualified by a real beat so idle grant cycles never write.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_wr;
        if (state == ST_DMA) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = beat & dma_we;
        end
    end

endmodule
